// File: rtl/debug_program_loader_if.sv
// Debug load/run bundle between the loader and its surroundings (UART receiver,
// datapath instruction-memory write port, datapath enable, debug unit status).
interface debug_program_loader_if #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32
);
  logic [7:0]                  i_rx_data;
  logic                        i_rx_done;
  logic                        i_halt;
  logic                        o_write_inst_mem;
  logic [PC_BITS-1:0]          o_inst_mem_addr;
  logic [INSTRUCTION_BITS-1:0] o_inst_mem_data;
  logic                        o_enable;
  logic                        o_busy;
  logic                        o_cmd_done;
  logic [7:0]                  o_cmd_code;

  modport master (
    input  i_rx_data, i_rx_done, i_halt,
    output o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
           o_enable, o_busy, o_cmd_done, o_cmd_code
  );

  modport slave (
    output i_rx_data, i_rx_done, i_halt,
    input  o_write_inst_mem, o_inst_mem_addr, o_inst_mem_data,
           o_enable, o_busy, o_cmd_done, o_cmd_code
  );
endinterface

// File: rtl/debug_program_loader.sv
// Decodes UART debug commands: loads instruction words into instruction memory,
// and gates the datapath enable for free-run or single-step execution.
module debug_program_loader #(
  parameter int                          PC_BITS          = 32,
  parameter int                          INSTRUCTION_BITS = 32,
  parameter int                          INST_MEM_DEPTH   = 256,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTR       = 32'hFFFFFFFF,
  parameter logic [7:0]                  CMD_LOAD         = 8'h01,
  parameter logic [7:0]                  CMD_RUN          = 8'h02,
  parameter logic [7:0]                  CMD_STEP         = 8'h03
) (
  input  logic                          clk,
  input  logic                          rst,
  debug_program_loader_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN,
    S_STEP
  } state_t;

  localparam logic [PC_BITS-1:0] LAST_ADDR = PC_BITS'(INST_MEM_DEPTH - 1);

  state_t                      state;
  logic [PC_BITS-1:0]          addr_cnt;
  logic [1:0]                  byte_cnt;
  logic [INSTRUCTION_BITS-1:0] word;
  logic [INSTRUCTION_BITS-1:0] word_next;

  // Bytes arrive most significant first, so each new byte enters at the bottom.
  always_comb begin
    word_next = {word[INSTRUCTION_BITS-9:0], bus.i_rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= S_IDLE;
      addr_cnt             <= '0;
      byte_cnt             <= '0;
      word                 <= '0;
      bus.o_write_inst_mem <= 1'b0;
      bus.o_inst_mem_addr  <= '0;
      bus.o_inst_mem_data  <= '0;
      bus.o_enable         <= 1'b0;
      bus.o_busy           <= 1'b0;
      bus.o_cmd_done       <= 1'b0;
      bus.o_cmd_code       <= '0;
    end else begin
      bus.o_write_inst_mem <= 1'b0;
      bus.o_cmd_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_rx_done) begin
            case (bus.i_rx_data)
              CMD_LOAD: begin
                state      <= S_LOAD;
                addr_cnt   <= '0;
                byte_cnt   <= '0;
                bus.o_busy <= 1'b1;
              end
              CMD_RUN: begin
                state        <= S_RUN;
                bus.o_enable <= 1'b1;
                bus.o_busy   <= 1'b1;
              end
              CMD_STEP: begin
                state        <= S_STEP;
                bus.o_enable <= 1'b1;
                bus.o_busy   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (bus.i_rx_done) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state                <= S_WRITE;
              bus.o_write_inst_mem <= 1'b1;
              bus.o_inst_mem_addr  <= addr_cnt;
              bus.o_inst_mem_data  <= word_next;
            end
          end
        end
        S_WRITE: begin
          addr_cnt <= addr_cnt + 1'b1;
          byte_cnt <= '0;
          // The halt word has just been written; a full memory ends the load without wrapping.
          if (word == HALT_INSTR || addr_cnt == LAST_ADDR) begin
            state          <= S_IDLE;
            bus.o_busy     <= 1'b0;
            bus.o_cmd_done <= 1'b1;
            bus.o_cmd_code <= CMD_LOAD;
          end else begin
            state <= S_LOAD;
          end
        end
        S_RUN: begin
          if (bus.i_halt) begin
            state          <= S_IDLE;
            bus.o_enable   <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_cmd_done <= 1'b1;
            bus.o_cmd_code <= CMD_RUN;
          end
        end
        S_STEP: begin
          state          <= S_IDLE;
          bus.o_enable   <= 1'b0;
          bus.o_busy     <= 1'b0;
          bus.o_cmd_done <= 1'b1;
          bus.o_cmd_code <= CMD_STEP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_program_loader.sv
// Directed bench for debug_program_loader: load, load overflow, run, step,
// ignored bytes and mid-load reset, with hand-computed expectations.
module tb_debug_program_loader;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   en_cycles;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  done_code[$];
  int          done_cyc[$];

  debug_program_loader_if #(.PC_BITS(32), .INSTRUCTION_BITS(32)) bus ();

  debug_program_loader #(
    .PC_BITS(32),
    .INSTRUCTION_BITS(32),
    .INST_MEM_DEPTH(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records DUT activity mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_write_inst_mem === 1'b1) begin
      wr_addr.push_back(bus.o_inst_mem_addr);
      wr_data.push_back(bus.o_inst_mem_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.o_cmd_done === 1'b1) begin
      done_code.push_back(bus.o_cmd_code);
      done_cyc.push_back(cyc);
    end
    if (bus.o_enable === 1'b1) en_cycles++;
  end

  // Returns #1 after the edge that sampled the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_paced(input logic [7:0] b);
    send_byte(b);
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.o_write_inst_mem !== 1'b0) $display("FAIL reset_write: got %b expected 0", bus.o_write_inst_mem); else n_pass++;
    n_chk++; if (bus.o_inst_mem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", bus.o_inst_mem_addr); else n_pass++;
    n_chk++; if (bus.o_inst_mem_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", bus.o_inst_mem_data); else n_pass++;
    n_chk++; if (bus.o_enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", bus.o_enable); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_cmd_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.o_cmd_done); else n_pass++;
    n_chk++; if (bus.o_cmd_code !== 8'h00) $display("FAIL reset_code: got %h expected 00", bus.o_cmd_code); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_load_basic;
    int wb = wr_addr.size();
    int db = done_code.size();
    send_paced(8'h01);
    n_chk++; if (bus.o_busy !== 1'b1) $display("FAIL load_busy: got %b expected 1", bus.o_busy); else n_pass++;
    send_paced(8'h12);
    send_paced(8'h34);
    send_paced(8'h56);
    send_byte(8'h78);
    // Strobe must be visible in the cycle right after the 4th byte is sampled.
    n_chk++; if (bus.o_write_inst_mem !== 1'b1) $display("FAIL load_latency: got %b expected 1", bus.o_write_inst_mem); else n_pass++;
    n_chk++; if (bus.o_inst_mem_data !== 32'h12345678) $display("FAIL load_word0_now: got %h expected 12345678", bus.o_inst_mem_data); else n_pass++;
    @(posedge clk);
    repeat (3) send_paced(8'hFF);
    send_paced(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (wr_addr.size() - wb !== 2) $display("FAIL load_write_count: got %0d expected 2", wr_addr.size() - wb); else n_pass++;
    if (wr_addr.size() >= wb + 2) begin
      n_chk++; if (wr_addr[wb] !== 32'd0) $display("FAIL load_addr0: got %0d expected 0", wr_addr[wb]); else n_pass++;
      n_chk++; if (wr_data[wb] !== 32'h12345678) $display("FAIL load_data0: got %h expected 12345678", wr_data[wb]); else n_pass++;
      n_chk++; if (wr_addr[wb+1] !== 32'd1) $display("FAIL load_addr1: got %0d expected 1", wr_addr[wb+1]); else n_pass++;
      n_chk++; if (wr_data[wb+1] !== 32'hFFFFFFFF) $display("FAIL load_data1: got %h expected ffffffff", wr_data[wb+1]); else n_pass++;
    end
    n_chk++; if (done_code.size() - db !== 1) $display("FAIL load_done_count: got %0d expected 1", done_code.size() - db); else n_pass++;
    if (done_code.size() > db && wr_cyc.size() >= wb + 2) begin
      n_chk++; if (done_code[db] !== 8'h01) $display("FAIL load_done_code: got %h expected 01", done_code[db]); else n_pass++;
      n_chk++; if (done_cyc[db] !== wr_cyc[wb+1] + 1) $display("FAIL load_done_timing: got cycle %0d expected %0d", done_cyc[db], wr_cyc[wb+1] + 1); else n_pass++;
    end
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL load_end_busy: got %b expected 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_inst_mem_addr !== 32'd1 || bus.o_inst_mem_data !== 32'hFFFFFFFF)
      $display("FAIL load_stale_hold: got %0d/%h expected 1/ffffffff", bus.o_inst_mem_addr, bus.o_inst_mem_data); else n_pass++;
  endtask

  task automatic test_load_full;
    int wb = wr_addr.size();
    int db = done_code.size();
    int last;
    logic [7:0] lo;
    send_paced(8'h01);
    for (int i = 0; i < 257; i++) begin
      lo = i[7:0];
      send_paced(8'hA0);
      send_paced(8'hB1);
      send_paced(8'hC2);
      send_paced(lo);
    end
    repeat (3) @(posedge clk);
    #1;
    last = wr_addr.size() - 1;
    n_chk++; if (wr_addr.size() - wb !== 256) $display("FAIL full_write_count: got %0d expected 256", wr_addr.size() - wb); else n_pass++;
    if (wr_addr.size() == wb + 256) begin
      n_chk++; if (wr_addr[wb] !== 32'd0) $display("FAIL full_first_addr: got %0d expected 0", wr_addr[wb]); else n_pass++;
      n_chk++; if (wr_data[wb+1] !== 32'hA0B1C201) $display("FAIL full_data1: got %h expected a0b1c201", wr_data[wb+1]); else n_pass++;
      n_chk++; if (wr_addr[last] !== 32'd255) $display("FAIL full_last_addr: got %0d expected 255", wr_addr[last]); else n_pass++;
      n_chk++; if (wr_data[last] !== 32'hA0B1C2FF) $display("FAIL full_last_data: got %h expected a0b1c2ff", wr_data[last]); else n_pass++;
    end
    n_chk++; if (done_code.size() - db !== 1) $display("FAIL full_done_count: got %0d expected 1", done_code.size() - db); else n_pass++;
    if (done_code.size() > db) begin
      n_chk++; if (done_code[db] !== 8'h01) $display("FAIL full_done_code: got %h expected 01", done_code[db]); else n_pass++;
      n_chk++; if (done_cyc[db] !== wr_cyc[last] + 1) $display("FAIL full_done_timing: got cycle %0d expected %0d", done_cyc[db], wr_cyc[last] + 1); else n_pass++;
    end
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL full_end_busy: got %b expected 0", bus.o_busy); else n_pass++;
  endtask

  task automatic test_run;
    int db = done_code.size();
    int e0 = en_cycles;
    send_byte(8'h02);
    n_chk++; if (bus.o_enable !== 1'b1) $display("FAIL run_enable_start: got %b expected 1", bus.o_enable); else n_pass++;
    repeat (9) @(posedge clk);
    #1 bus.i_halt = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.o_enable !== 1'b0) $display("FAIL run_enable_drop: got %b expected 0", bus.o_enable); else n_pass++;
    n_chk++; if (bus.o_cmd_done !== 1'b1 || bus.o_cmd_code !== 8'h02)
      $display("FAIL run_done_pulse: got %b/%h expected 1/02", bus.o_cmd_done, bus.o_cmd_code); else n_pass++;
    bus.i_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (en_cycles - e0 !== 10) $display("FAIL run_enable_cycles: got %0d expected 10", en_cycles - e0); else n_pass++;
    n_chk++; if (done_code.size() - db !== 1) $display("FAIL run_done_count: got %0d expected 1", done_code.size() - db); else n_pass++;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL run_end_busy: got %b expected 0", bus.o_busy); else n_pass++;
  endtask

  task automatic test_step;
    int db = done_code.size();
    int e0 = en_cycles;
    for (int k = 0; k < 3; k++) begin
      // Halt held high on the last step must not change the single-cycle pulse.
      if (k == 2) bus.i_halt = 1'b1;
      send_byte(8'h03);
      n_chk++; if (bus.o_enable !== 1'b1 || bus.o_cmd_done !== 1'b0)
        $display("FAIL step%0d_enable: got en=%b done=%b expected en=1 done=0", k, bus.o_enable, bus.o_cmd_done); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (bus.o_enable !== 1'b0 || bus.o_cmd_done !== 1'b1)
        $display("FAIL step%0d_drop: got en=%b done=%b expected en=0 done=1", k, bus.o_enable, bus.o_cmd_done); else n_pass++;
      n_chk++; if (bus.o_cmd_code !== 8'h03) $display("FAIL step%0d_code: got %h expected 03", k, bus.o_cmd_code); else n_pass++;
      bus.i_halt = 1'b0;
      repeat (2) @(posedge clk);
    end
    #1;
    n_chk++; if (en_cycles - e0 !== 3) $display("FAIL step_enable_cycles: got %0d expected 3", en_cycles - e0); else n_pass++;
    n_chk++; if (done_code.size() - db !== 3) $display("FAIL step_done_count: got %0d expected 3", done_code.size() - db); else n_pass++;
  endtask

  task automatic test_ignored_bytes;
    int db = done_code.size();
    int e0 = en_cycles;
    send_paced(8'h55);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.o_busy !== 1'b0 || bus.o_enable !== 1'b0)
      $display("FAIL ign_idle_state: got busy=%b en=%b expected 0/0", bus.o_busy, bus.o_enable); else n_pass++;
    n_chk++; if (done_code.size() - db !== 0) $display("FAIL ign_no_done: got %0d expected 0", done_code.size() - db); else n_pass++;
    send_byte(8'h02);
    send_byte(8'h01);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.o_busy !== 1'b1 || bus.o_enable !== 1'b1)
      $display("FAIL ign_run_continues: got busy=%b en=%b expected 1/1", bus.o_busy, bus.o_enable); else n_pass++;
    n_chk++; if (done_code.size() - db !== 0) $display("FAIL ign_run_no_done: got %0d expected 0", done_code.size() - db); else n_pass++;
    bus.i_halt = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (bus.o_enable !== 1'b0 || bus.o_cmd_done !== 1'b1 || bus.o_cmd_code !== 8'h02)
      $display("FAIL ign_run_end: got en=%b done=%b code=%h expected 0/1/02", bus.o_enable, bus.o_cmd_done, bus.o_cmd_code); else n_pass++;
    bus.i_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (en_cycles - e0 !== 5) $display("FAIL ign_enable_cycles: got %0d expected 5", en_cycles - e0); else n_pass++;
  endtask

  task automatic test_reset_mid_load;
    int wb = wr_addr.size();
    int db = done_code.size();
    send_paced(8'h01);
    send_paced(8'hAB);
    send_byte(8'hCD);
    n_chk++; if (bus.o_busy !== 1'b1) $display("FAIL rml_busy_before: got %b expected 1", bus.o_busy); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++; if (bus.o_busy !== 1'b0) $display("FAIL rml_busy: got %b expected 0", bus.o_busy); else n_pass++;
    n_chk++; if (bus.o_inst_mem_addr !== 32'h0) $display("FAIL rml_addr: got %h expected 0", bus.o_inst_mem_addr); else n_pass++;
    n_chk++; if (bus.o_inst_mem_data !== 32'h0) $display("FAIL rml_data: got %h expected 0", bus.o_inst_mem_data); else n_pass++;
    n_chk++; if (bus.o_cmd_code !== 8'h00) $display("FAIL rml_code: got %h expected 00", bus.o_cmd_code); else n_pass++;
    n_chk++; if (bus.o_enable !== 1'b0 || bus.o_write_inst_mem !== 1'b0 || bus.o_cmd_done !== 1'b0)
      $display("FAIL rml_strobes: got en=%b wr=%b done=%b expected 0/0/0", bus.o_enable, bus.o_write_inst_mem, bus.o_cmd_done); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    send_paced(8'h01);
    send_paced(8'h11);
    send_paced(8'h22);
    send_paced(8'h33);
    send_paced(8'h44);
    repeat (4) send_paced(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (wr_addr.size() - wb !== 2) $display("FAIL rml_write_count: got %0d expected 2", wr_addr.size() - wb); else n_pass++;
    if (wr_addr.size() >= wb + 2) begin
      n_chk++; if (wr_addr[wb] !== 32'd0) $display("FAIL rml_addr0: got %0d expected 0", wr_addr[wb]); else n_pass++;
      n_chk++; if (wr_data[wb] !== 32'h11223344) $display("FAIL rml_data0: got %h expected 11223344", wr_data[wb]); else n_pass++;
      n_chk++; if (wr_addr[wb+1] !== 32'd1 || wr_data[wb+1] !== 32'hFFFFFFFF)
        $display("FAIL rml_word1: got %0d/%h expected 1/ffffffff", wr_addr[wb+1], wr_data[wb+1]); else n_pass++;
    end
    n_chk++; if (done_code.size() - db !== 1) $display("FAIL rml_done_count: got %0d expected 1", done_code.size() - db); else n_pass++;
    if (done_code.size() > db) begin
      n_chk++; if (done_code[db] !== 8'h01) $display("FAIL rml_done_code: got %h expected 01", done_code[db]); else n_pass++;
    end
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    cyc           = 0;
    en_cycles     = 0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    test_reset();
    test_load_basic();
    test_load_full();
    test_run();
    test_step();
    test_ignored_bytes();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
